// File: rtl/control_fsm.sv
// Multicycle RV32I control unit: fetch/decode/execute sequencing and datapath select generation.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap undecoded opcodes in HALT and expose `illegal`.

package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;
  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;
  typedef enum logic [2:0] {
    lb = 3'b000, lh = 3'b001, lw = 3'b010, lbu = 3'b100, lhu = 3'b101
  } load_funct3_t;
  typedef enum logic [2:0] {
    sb = 3'b000, sh = 3'b001, sw = 3'b010
  } store_funct3_t;
  typedef enum logic [2:0] {
    add = 3'b000, sll = 3'b001, slt = 3'b010, sltu = 3'b011,
    axor = 3'b100, sr = 3'b101, aor = 3'b110, aand = 3'b111
  } arith_funct3_t;
  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or = 3'b110, alu_and = 3'b111
  } alu_ops;
endpackage

package pcmux;
  typedef enum logic [1:0] { pc_plus4 = 2'b00, alu_out = 2'b01, alu_mod2 = 2'b10 } pcmux_sel_t;
endpackage

package marmux;
  typedef enum logic { pc_out = 1'b0, alu_out = 1'b1 } marmux_sel_t;
endpackage

package cmpmux;
  typedef enum logic { rs2_out = 1'b0, i_imm = 1'b1 } cmpmux_sel_t;
endpackage

package alumux;
  typedef enum logic { rs1_out = 1'b0, pc_out = 1'b1 } alumux1_sel_t;
  typedef enum logic [2:0] {
    i_imm = 3'd0, u_imm = 3'd1, b_imm = 3'd2, s_imm = 3'd3, j_imm = 3'd4, rs2_out = 3'd5
  } alumux2_sel_t;
endpackage

package regfilemux;
  typedef enum logic [3:0] {
    alu_out = 4'd0, br_en = 4'd1, u_imm = 4'd2, lw = 4'd3, pc_plus4 = 4'd4,
    lb = 4'd5, lbu = 4'd6, lh = 4'd7, lhu = 4'd8
  } regfilemux_sel_t;
endpackage

module control_fsm (
  input  logic                         clk,
  input  logic                         rst,
  input  rv32i_types::rv32i_opcode     opcode,
  input  logic [2:0]                   funct3,
  input  logic [6:0]                   funct7,
  input  logic                         br_en,
  input  logic [1:0]                   mem_addr_lo,
  input  logic                         mem_resp,
  output logic                         load_pc,
  output logic                         load_ir,
  output logic                         load_regfile,
  output logic                         load_mar,
  output logic                         load_mdr,
  output logic                         load_data_out,
  output pcmux::pcmux_sel_t            pcmux_sel,
  output alumux::alumux1_sel_t         alumux1_sel,
  output alumux::alumux2_sel_t         alumux2_sel,
  output regfilemux::regfilemux_sel_t  regfilemux_sel,
  output marmux::marmux_sel_t          marmux_sel,
  output cmpmux::cmpmux_sel_t          cmpmux_sel,
  output rv32i_types::alu_ops          aluop,
  output rv32i_types::branch_funct3_t  cmpop,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic                         illegal,
`endif
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [3:0]                   mem_byte_enable
);
  import rv32i_types::*;

  localparam logic [4:0] FETCH1    = 5'd0;
  localparam logic [4:0] FETCH2    = 5'd1;
  localparam logic [4:0] FETCH3    = 5'd2;
  localparam logic [4:0] DECODE    = 5'd3;
  localparam logic [4:0] IMM       = 5'd4;
  localparam logic [4:0] REG       = 5'd5;
  localparam logic [4:0] LUI       = 5'd6;
  localparam logic [4:0] AUIPC     = 5'd7;
  localparam logic [4:0] BR        = 5'd8;
  localparam logic [4:0] JAL       = 5'd9;
  localparam logic [4:0] JALR      = 5'd10;
  localparam logic [4:0] CALC_ADDR = 5'd11;
  localparam logic [4:0] LD1       = 5'd12;
  localparam logic [4:0] LD2       = 5'd13;
  localparam logic [4:0] ST1       = 5'd14;
  localparam logic [4:0] ST2       = 5'd15;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [4:0] HALT      = 5'd16;
`endif

  logic [4:0] state, next_state;
  logic       unused_funct7;

  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH1;
    else      state <= next_state;
  end

  // Outputs are also gated by rst so they read as defaults while reset is held.
  always_comb begin
    load_pc         = 1'b0;
    load_ir         = 1'b0;
    load_regfile    = 1'b0;
    load_mar        = 1'b0;
    load_mdr        = 1'b0;
    load_data_out   = 1'b0;
    pcmux_sel       = pcmux::pc_plus4;
    alumux1_sel     = alumux::rs1_out;
    alumux2_sel     = alumux::i_imm;
    regfilemux_sel  = regfilemux::alu_out;
    marmux_sel      = marmux::pc_out;
    cmpmux_sel      = cmpmux::rs2_out;
    aluop           = alu_add;
    cmpop           = beq;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_byte_enable = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal         = 1'b0;
`endif
    next_state      = state;
    if (rst) begin
      case (state)
        FETCH1: begin
          load_mar   = 1'b1;
          marmux_sel = marmux::pc_out;
          next_state = FETCH2;
        end
        FETCH2: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (mem_resp) next_state = FETCH3;
        end
        FETCH3: begin
          load_ir    = 1'b1;
          next_state = DECODE;
        end
        DECODE: begin
          case (opcode)
            op_imm:             next_state = IMM;
            op_reg:             next_state = REG;
            op_lui:             next_state = LUI;
            op_auipc:           next_state = AUIPC;
            op_br:              next_state = BR;
            op_jal:             next_state = JAL;
            op_jalr:            next_state = JALR;
            op_load, op_store:  next_state = CALC_ADDR;
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              next_state = HALT;
`else
              load_pc    = 1'b1;
              pcmux_sel  = pcmux::pc_plus4;
              next_state = FETCH1;
`endif
            end
          endcase
        end
        IMM, REG: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          aluop        = alu_ops'(funct3);
          if (state == REG) alumux2_sel = alumux::rs2_out;
          if (funct3 == sr && funct7[5]) aluop = alu_sra;
          if (state == REG && funct3 == add && funct7[5]) aluop = alu_sub;
          if (funct3 == slt || funct3 == sltu) begin
            cmpop          = (funct3 == slt) ? blt : bltu;
            cmpmux_sel     = (state == IMM) ? cmpmux::i_imm : cmpmux::rs2_out;
            regfilemux_sel = regfilemux::br_en;
          end
          next_state = FETCH1;
        end
        LUI: begin
          load_regfile   = 1'b1;
          regfilemux_sel = regfilemux::u_imm;
          load_pc        = 1'b1;
          next_state     = FETCH1;
        end
        AUIPC: begin
          load_regfile = 1'b1;
          alumux1_sel  = alumux::pc_out;
          alumux2_sel  = alumux::u_imm;
          load_pc      = 1'b1;
          next_state   = FETCH1;
        end
        BR: begin
          cmpop       = branch_funct3_t'(funct3);
          cmpmux_sel  = cmpmux::rs2_out;
          alumux1_sel = alumux::pc_out;
          alumux2_sel = alumux::b_imm;
          load_pc     = 1'b1;
          pcmux_sel   = br_en ? pcmux::alu_out : pcmux::pc_plus4;
          next_state  = FETCH1;
        end
        JAL: begin
          load_regfile   = 1'b1;
          regfilemux_sel = regfilemux::pc_plus4;
          alumux1_sel    = alumux::pc_out;
          alumux2_sel    = alumux::j_imm;
          load_pc        = 1'b1;
          pcmux_sel      = pcmux::alu_out;
          next_state     = FETCH1;
        end
        JALR: begin
          load_regfile   = 1'b1;
          regfilemux_sel = regfilemux::pc_plus4;
          load_pc        = 1'b1;
          pcmux_sel      = pcmux::alu_mod2;
          next_state     = FETCH1;
        end
        CALC_ADDR: begin
          load_mar   = 1'b1;
          marmux_sel = marmux::alu_out;
          if (opcode == op_store) begin
            alumux2_sel   = alumux::s_imm;
            load_data_out = 1'b1;
            next_state    = ST1;
          end else begin
            next_state = LD1;
          end
        end
        LD1: begin
          mem_read = 1'b1;
          load_mdr = 1'b1;
          if (mem_resp) next_state = LD2;
        end
        LD2: begin
          load_regfile = 1'b1;
          load_pc      = 1'b1;
          case (load_funct3_t'(funct3))
            rv32i_types::lb:  regfilemux_sel = regfilemux::lb;
            rv32i_types::lh:  regfilemux_sel = regfilemux::lh;
            rv32i_types::lbu: regfilemux_sel = regfilemux::lbu;
            rv32i_types::lhu: regfilemux_sel = regfilemux::lhu;
            default:          regfilemux_sel = regfilemux::lw;
          endcase
          next_state = FETCH1;
        end
        ST1: begin
          mem_write = 1'b1;
          case (store_funct3_t'(funct3))
            sb:      mem_byte_enable = 4'b0001 << mem_addr_lo;
            sh:      mem_byte_enable = 4'b0011 << mem_addr_lo;
            default: mem_byte_enable = 4'b1111;
          endcase
          if (mem_resp) next_state = ST2;
        end
        ST2: begin
          load_pc    = 1'b1;
          next_state = FETCH1;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        HALT: illegal = 1'b1;
`endif
        default: next_state = FETCH1;
      endcase
    end
  end
endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm; honours CTRL_ILLEGAL_TRAP_EN when defined.
module tb_control_fsm;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst;
  rv32i_opcode opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic br_en, mem_resp;
  logic [1:0] mem_addr_lo;
  logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
  pcmux::pcmux_sel_t pcmux_sel;
  alumux::alumux1_sel_t alumux1_sel;
  alumux::alumux2_sel_t alumux2_sel;
  regfilemux::regfilemux_sel_t regfilemux_sel;
  marmux::marmux_sel_t marmux_sel;
  cmpmux::cmpmux_sel_t cmpmux_sel;
  alu_ops aluop;
  branch_funct3_t cmpop;
  logic mem_read, mem_write;
  logic [3:0] mem_byte_enable;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fails = 0;

  control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .br_en(br_en), .mem_addr_lo(mem_addr_lo), .mem_resp(mem_resp),
    .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile),
    .load_mar(load_mar), .load_mdr(load_mdr), .load_data_out(load_data_out),
    .pcmux_sel(pcmux_sel), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
    .regfilemux_sel(regfilemux_sel), .marmux_sel(marmux_sel), .cmpmux_sel(cmpmux_sel),
    .aluop(aluop), .cmpop(cmpop),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal(illegal),
`endif
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Starts in FETCH1, returns in DECODE with the given instruction fields applied.
  task automatic do_fetch(input rv32i_opcode op, input logic [2:0] f3, input logic [6:0] f7,
                          input int unsigned waits);
    int unsigned n;
    opcode = op; funct3 = f3; funct7 = f7; mem_resp = 1'b0;
    check_eq("f1_load_mar", 32'(load_mar), 32'd1);
    tick();
    n = 0;
    for (int unsigned i = 0; i < waits; i++) begin
      if (mem_read && load_mdr) n++;
      tick();
    end
    if (mem_read && load_mdr) n++;
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    check_eq("f2_cycles", n, waits + 1);
    check_eq("f3_load_ir", 32'(load_ir), 32'd1);
    tick();
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [1:0] lo, input logic [3:0] exp_be);
    mem_addr_lo = lo;
    do_fetch(op_store, f3, 7'd0, 0);
    tick();
    check_eq("calc_st_dout", 32'(load_data_out), 32'd1);
    check_eq("calc_st_imm", 32'(alumux2_sel), 32'(alumux::s_imm));
    tick();
    check_eq("st1_be", 32'(mem_byte_enable), 32'(exp_be));
    tick();
    check_eq("st1_be_hold", 32'(mem_byte_enable), 32'(exp_be));
    check_eq("st1_write_hold", 32'(mem_write), 32'd1);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    check_eq("st2_be_zero", 32'(mem_byte_enable), 32'd0);
    check_eq("st2_load_pc", 32'(load_pc), 32'd1);
    tick();
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [3:0] exp_sel);
    do_fetch(op_load, f3, 7'd0, 1);
    tick();
    check_eq("calc_ld_marmux", 32'(marmux_sel), 32'(marmux::alu_out));
    check_eq("calc_ld_dout", 32'(load_data_out), 32'd0);
    tick();
    check_eq("ld1_read", 32'(mem_read), 32'd1);
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    check_eq("ld2_regfilemux", 32'(regfilemux_sel), 32'(exp_sel));
    check_eq("ld2_load_pc", 32'(load_pc), 32'd1);
    tick();
  endtask

  initial begin
    rst = 1'b0; opcode = op_imm; funct3 = '0; funct7 = '0;
    br_en = 1'b0; mem_addr_lo = '0; mem_resp = 1'b0;
    #1;
    check_eq("rst_load_mar", 32'(load_mar), 32'd0);
    check_eq("rst_mem_read", 32'(mem_read), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_eq("rel_marmux", 32'(marmux_sel), 32'(marmux::pc_out));

    // addi with three wait states
    do_fetch(op_imm, 3'b000, 7'd0, 3);
    check_eq("dec_no_regfile", 32'(load_regfile), 32'd0);
    tick();
    check_eq("addi_regfile", 32'(load_regfile), 32'd1);
    check_eq("addi_aluop", 32'(aluop), 32'(alu_add));
    check_eq("addi_pcmux", 32'(pcmux_sel), 32'(pcmux::pc_plus4));
    tick();
    check_eq("addi_regfile_once", 32'(load_regfile), 32'd0);

    // funct7[5] is SRA in IMM, but never SUB in IMM
    do_fetch(op_imm, 3'b101, 7'b0100000, 0); tick();
    check_eq("srai_aluop", 32'(aluop), 32'(alu_sra));
    tick();
    do_fetch(op_imm, 3'b000, 7'b0100000, 0); tick();
    check_eq("imm_no_sub", 32'(aluop), 32'(alu_add));
    tick();
    do_fetch(op_reg, 3'b000, 7'b0100000, 0); tick();
    check_eq("sub_aluop", 32'(aluop), 32'(alu_sub));
    check_eq("sub_alumux2", 32'(alumux2_sel), 32'(alumux::rs2_out));
    tick();
    do_fetch(op_reg, 3'b010, 7'd0, 0); tick();
    check_eq("slt_cmpop", 32'(cmpop), 32'(blt));
    check_eq("slt_regfilemux", 32'(regfilemux_sel), 32'(regfilemux::br_en));
    check_eq("slt_cmpmux", 32'(cmpmux_sel), 32'(cmpmux::rs2_out));
    tick();
    do_fetch(op_imm, 3'b011, 7'd0, 0); tick();
    check_eq("sltiu_cmpop", 32'(cmpop), 32'(bltu));
    check_eq("sltiu_cmpmux", 32'(cmpmux_sel), 32'(cmpmux::i_imm));
    tick();

    // beq taken / not taken, 5 cycles each
    br_en = 1'b1;
    do_fetch(op_br, 3'b000, 7'd0, 0); tick();
    check_eq("beq_taken_pcmux", 32'(pcmux_sel), 32'(pcmux::alu_out));
    check_eq("beq_alumux2", 32'(alumux2_sel), 32'(alumux::b_imm));
    tick();
    check_eq("beq_back_fetch", 32'(load_mar), 32'd1);
    br_en = 1'b0;
    do_fetch(op_br, 3'b000, 7'd0, 0); tick();
    check_eq("beq_nt_pcmux", 32'(pcmux_sel), 32'(pcmux::pc_plus4));
    check_eq("beq_load_pc", 32'(load_pc), 32'd1);
    tick();

    // JAL with a stray mem_resp in a non-waiting state
    do_fetch(op_jal, 3'b000, 7'd0, 0);
    mem_resp = 1'b1;
    tick();
    check_eq("jal_pcmux", 32'(pcmux_sel), 32'(pcmux::alu_out));
    check_eq("jal_regfilemux", 32'(regfilemux_sel), 32'(regfilemux::pc_plus4));
    check_eq("jal_alumux2", 32'(alumux2_sel), 32'(alumux::j_imm));
    tick();
    mem_resp = 1'b0;
    check_eq("jal_fetch1", 32'(load_mar), 32'd1);
    do_fetch(op_jalr, 3'b000, 7'd0, 0); tick();
    check_eq("jalr_pcmux", 32'(pcmux_sel), 32'(pcmux::alu_mod2));
    tick();
    do_fetch(op_auipc, 3'b000, 7'd0, 0); tick();
    check_eq("auipc_alumux1", 32'(alumux1_sel), 32'(alumux::pc_out));
    check_eq("auipc_alumux2", 32'(alumux2_sel), 32'(alumux::u_imm));
    tick();

    do_store(3'b000, 2'd2, 4'b0100);
    do_store(3'b001, 2'd2, 4'b1100);
    do_store(3'b010, 2'd0, 4'b1111);
    do_load(3'b100, 4'(regfilemux::lbu));
    do_load(3'b001, 4'(regfilemux::lh));
    do_load(3'b010, 4'(regfilemux::lw));

    // reset asserted mid-LD1
    do_fetch(op_load, 3'b010, 7'd0, 0);
    tick(); tick();
    check_eq("ld1_pre_rst", 32'(mem_read), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rst_drop_read", 32'(mem_read), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1;
    opcode = op_lui;
    #1;
    check_eq("rel_fetch1", 32'(load_mar), 32'd1);
    tick();
    check_eq("rel_fetch2", 32'(mem_read), 32'd1);
    mem_resp = 1'b1; tick(); mem_resp = 1'b0;
    tick(); tick();
    check_eq("lui_regfilemux", 32'(regfilemux_sel), 32'(regfilemux::u_imm));
    tick();

    // undecoded opcode
    do_fetch(rv32i_opcode'(7'b0000000), 3'b000, 7'd0, 0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    tick();
    for (int i = 0; i < 10; i++) begin
      check_eq("halt_illegal", 32'(illegal), 32'd1);
      check_eq("halt_no_loads", 32'({load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out}), 32'd0);
      tick();
    end
    rst = 1'b0; #1;
    check_eq("halt_rst_clear", 32'(illegal), 32'd0);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    check_eq("halt_rel_fetch", 32'(load_mar), 32'd1);
`else
    check_eq("nop_load_pc", 32'(load_pc), 32'd1);
    check_eq("nop_pcmux", 32'(pcmux_sel), 32'(pcmux::pc_plus4));
    tick();
    check_eq("nop_fetch1", 32'(load_mar), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
